// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding,
// ALU function codes and IR class codes.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_F_ADDR  = 4'd0,
    S_F_MEM   = 4'd1,
    S_F_IR    = 4'd2,
    S_DECODE  = 4'd3,
    S_ALU_EX  = 4'd4,
    S_MOV_EX  = 4'd5,
    S_LD_ADDR = 4'd6,
    S_LD_MEM  = 4'd7,
    S_LD_WB   = 4'd8,
    S_ST_ADDR = 4'd9,
    S_ST_DATA = 4'd10,
    S_ST_MEM  = 4'd11,
    S_BR_EVAL = 4'd12,
    S_BR_TAKE = 4'd13,
    S_HALT    = 4'd14,
    S_ERR     = 4'd15
  } state_t;

  localparam logic [2:0] FN_PASS = 3'b100;
  localparam logic [2:0] FN_INC  = 3'b101;

  localparam logic [3:0] OP_DATA  = 4'b0000;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [3:0] OP_BR_LO = 4'b0001;
  localparam logic [3:0] OP_BR_HI = 4'b1001;

  function automatic logic is_branch(input logic [3:0] op);
    return (op >= OP_BR_LO) && (op <= OP_BR_HI);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of a pending memory request and flags a timeout on the
// cycle the count reaches MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic busy_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Mem states are never adjacent, so clearing whenever idle or ready
  // guarantees a zero count on every request entry.
  always_comb begin
    cnt_d = '0;
    if (busy_i && !ready_i) cnt_d = cnt_q + 1'b1;
  end

  assign timeout_o = busy_i && !ready_i && (cnt_d == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control FSM for the 16-bit datapath,
// including the memory request handshake with wait states and timeout.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ir_1,
  input  logic [1:0] ir_2,
  input  logic [1:0] ir_3,
  input  logic [2:0] ir_4,
  input  logic       cc,
  input  logic       mem_ready,
  output logic       ldMAR,
  output logic       ldIR,
  output logic       Tlabel,
  output logic       ALUon,
  output logic [2:0] fnSelect,
  output logic       mm,
  output logic       ldMDR,
  output logic       ldFlag,
  output logic       pc_out,
  output logic       ldPC,
  output logic       ldReg,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted,
  output logic       error
);

  state_t state_q, state_d;
  logic   mem_busy, timeout;
  logic   unused_ir;

  assign unused_ir = ^{ir_3, ir_4};
  assign mem_busy  = (state_q == S_F_MEM) || (state_q == S_LD_MEM) ||
                     (state_q == S_ST_MEM);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .busy_i    (mem_busy),
    .ready_i   (mem_ready),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_F_ADDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ldMAR    = 1'b0;
    ldIR     = 1'b0;
    Tlabel   = 1'b0;
    ALUon    = 1'b0;
    fnSelect = FN_PASS;
    mm       = 1'b1;
    ldMDR    = 1'b0;
    ldFlag   = 1'b0;
    pc_out   = 1'b0;
    ldPC     = 1'b0;
    ldReg    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;
    error    = 1'b0;

    unique case (state_q)
      S_F_ADDR: begin
        pc_out  = 1'b1;
        ldMAR   = 1'b1;
        state_d = S_F_MEM;
      end
      S_F_MEM, S_LD_MEM: begin
        mem_rd = 1'b1;
        mm     = 1'b0;
        ldMDR  = mem_ready;
        if (timeout)        state_d = S_ERR;
        else if (mem_ready) state_d = (state_q == S_F_MEM) ? S_F_IR : S_LD_WB;
      end
      S_F_IR: begin
        ldIR     = 1'b1;
        pc_out   = 1'b1;
        fnSelect = FN_INC;
        ldPC     = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (ir_1 == OP_DATA) begin
          unique case (ir_2)
            2'b00: state_d = S_ALU_EX;
            2'b01: state_d = S_LD_ADDR;
            2'b10: state_d = S_ST_ADDR;
            2'b11: state_d = S_MOV_EX;
          endcase
        end
        else if (is_branch(ir_1)) state_d = S_BR_EVAL;
        else if (ir_1 == OP_HALT) state_d = S_HALT;
        else                      state_d = S_F_ADDR;
      end
      S_ALU_EX: begin
        ALUon   = 1'b1;
        ldFlag  = 1'b1;
        ldReg   = 1'b1;
        state_d = S_F_ADDR;
      end
      S_MOV_EX: begin
        ldReg   = 1'b1;
        state_d = S_F_ADDR;
      end
      S_LD_ADDR: begin
        ldMAR   = 1'b1;
        state_d = S_LD_MEM;
      end
      S_LD_WB: begin
        ldReg   = 1'b1;
        ldFlag  = 1'b1;
        state_d = S_F_ADDR;
      end
      S_ST_ADDR: begin
        ldMAR   = 1'b1;
        state_d = S_ST_DATA;
      end
      S_ST_DATA: begin
        ldMDR   = 1'b1;
        state_d = S_ST_MEM;
      end
      S_ST_MEM: begin
        mem_wr = 1'b1;
        if (timeout)        state_d = S_ERR;
        else if (mem_ready) state_d = S_F_ADDR;
      end
      S_BR_EVAL: begin
        Tlabel  = 1'b1;
        state_d = cc ? S_BR_TAKE : S_F_ADDR;
      end
      S_BR_TAKE: begin
        Tlabel  = 1'b1;
        ldPC    = 1'b1;
        state_d = S_F_ADDR;
      end
      S_HALT: halted = 1'b1;
      S_ERR:  error  = 1'b1;
      default: state_d = S_F_ADDR;
    endcase

    // Strobes are forced idle while reset is held, so a request pending at
    // reset is dropped immediately and F_ADDR shows no strobes until release.
    if (reset) begin
      ldMAR    = 1'b0;
      ldIR     = 1'b0;
      Tlabel   = 1'b0;
      ALUon    = 1'b0;
      fnSelect = FN_PASS;
      mm       = 1'b1;
      ldMDR    = 1'b0;
      ldFlag   = 1'b0;
      pc_out   = 1'b0;
      ldPC     = 1'b0;
      ldReg    = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      halted   = 1'b0;
      error    = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: every cycle compares the full strobe
// vector against a hand-written per-state constant.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ir_1;
  logic [1:0] ir_2, ir_3;
  logic [2:0] ir_4;
  logic       cc, mem_ready;
  logic       ldMAR, ldIR, Tlabel, ALUon, mm, ldMDR, ldFlag, pc_out, ldPC;
  logic       ldReg, mem_rd, mem_wr, halted, error;
  logic [2:0] fnSelect;
  logic [16:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .ir_1(ir_1), .ir_2(ir_2), .ir_3(ir_3),
    .ir_4(ir_4), .cc(cc), .mem_ready(mem_ready), .ldMAR(ldMAR), .ldIR(ldIR),
    .Tlabel(Tlabel), .ALUon(ALUon), .fnSelect(fnSelect), .mm(mm),
    .ldMDR(ldMDR), .ldFlag(ldFlag), .pc_out(pc_out), .ldPC(ldPC),
    .ldReg(ldReg), .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted),
    .error(error)
  );

  // {ldMAR ldIR Tlabel ALUon}_{fnSelect}_{mm ldMDR ldFlag pc_out}_{ldPC ldReg mem_rd mem_wr}_{halted error}
  assign outs = {ldMAR, ldIR, Tlabel, ALUon, fnSelect, mm, ldMDR, ldFlag, pc_out,
                 ldPC, ldReg, mem_rd, mem_wr, halted, error};

  localparam logic [16:0] E_IDLE   = 17'b0000_100_1000_0000_00;
  localparam logic [16:0] E_FADDR  = 17'b1000_100_1001_0000_00;
  localparam logic [16:0] E_MEMW   = 17'b0000_100_0000_0010_00;
  localparam logic [16:0] E_MEMR   = 17'b0000_100_0100_0010_00;
  localparam logic [16:0] E_FIR    = 17'b0100_101_1001_1000_00;
  localparam logic [16:0] E_DEC    = 17'b0000_100_1000_0000_00;
  localparam logic [16:0] E_ALU    = 17'b0001_100_1010_0100_00;
  localparam logic [16:0] E_MOV    = 17'b0000_100_1000_0100_00;
  localparam logic [16:0] E_MAR    = 17'b1000_100_1000_0000_00;
  localparam logic [16:0] E_LDWB   = 17'b0000_100_1010_0100_00;
  localparam logic [16:0] E_STDATA = 17'b0000_100_1100_0000_00;
  localparam logic [16:0] E_STMEM  = 17'b0000_100_1000_0001_00;
  localparam logic [16:0] E_BREVAL = 17'b0010_100_1000_0000_00;
  localparam logic [16:0] E_BRTAKE = 17'b0010_100_1000_1000_00;
  localparam logic [16:0] E_HALT   = 17'b0000_100_1000_0000_10;
  localparam logic [16:0] E_ERR    = 17'b0000_100_1000_0000_01;

  task automatic chk(input logic [16:0] exp, input string tag);
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
    end
  endtask

  task automatic chk_state(input state_t exp, input string tag);
    checks++;
    assert (dut.state_q === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dut.state_q, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic [16:0] exp, input string tag);
    @(posedge clk);
    #2 mem_ready = rdy;
    #1 chk(exp, tag);
  endtask

  task automatic fetch();
    step(1'b1, E_MEMR, "fetch_mem");
    step(1'b0, E_FIR,  "fetch_ir");
    step(1'b0, E_DEC,  "decode");
  endtask

  task automatic set_ir(input logic [3:0] a, input logic [1:0] b, input logic c);
    ir_1 = a;
    ir_2 = b;
    cc   = c;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    mem_ready = 1'b0;
    #0 chk(E_IDLE, {tag, "_gate"});
    @(posedge clk); #3;
    chk(E_IDLE, {tag, "_c1"});
    chk_state(S_F_ADDR, {tag, "_st1"});
    @(posedge clk); #3;
    chk(E_IDLE, {tag, "_c2"});
    chk_state(S_F_ADDR, {tag, "_st2"});
    reset = 1'b0;
    #1 chk(E_FADDR, {tag, "_rel"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ir_1 = '0; ir_2 = '0; ir_3 = 2'b10; ir_4 = 3'b011;
    cc = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    chk(E_IDLE, "rst_init");
    chk_state(S_F_ADDR, "rst_init_st");
    reset = 1'b0;
    #1 chk(E_FADDR, "rst_release");

    // ALU op, zero-wait fetch: F_ADDR, F_MEM, F_IR, DECODE, ALU_EX
    set_ir(4'b0000, 2'b00, 1'b0);
    fetch();
    step(1'b0, E_ALU,   "alu_ex");
    step(1'b0, E_FADDR, "alu_back");

    // Load with three wait states
    set_ir(4'b0000, 2'b01, 1'b0);
    fetch();
    step(1'b0, E_MAR,   "ld_addr");
    step(1'b0, E_MEMW,  "ld_w1");
    step(1'b0, E_MEMW,  "ld_w2");
    step(1'b0, E_MEMW,  "ld_w3");
    step(1'b1, E_MEMR,  "ld_rdy");
    step(1'b1, E_LDWB,  "ld_wb");
    step(1'b0, E_FADDR, "ld_back");

    // Move
    set_ir(4'b0000, 2'b11, 1'b0);
    fetch();
    step(1'b0, E_MOV,   "mov_ex");
    step(1'b0, E_FADDR, "mov_back");

    // Branch taken, then not taken
    set_ir(4'b0010, 2'b00, 1'b1);
    fetch();
    step(1'b0, E_BREVAL, "br1_eval");
    step(1'b0, E_BRTAKE, "br1_take");
    step(1'b0, E_FADDR,  "br1_back");
    set_ir(4'b1001, 2'b00, 1'b0);
    fetch();
    step(1'b0, E_BREVAL, "br0_eval");
    step(1'b0, E_FADDR,  "br0_back");

    // NOP class
    set_ir(4'b1010, 2'b00, 1'b1);
    fetch();
    step(1'b0, E_FADDR, "nop_back");

    // Store: 15 wait cycles then ready on the 16th is still in time
    set_ir(4'b0000, 2'b10, 1'b0);
    fetch();
    step(1'b0, E_MAR,    "st_addr");
    step(1'b0, E_STDATA, "st_data");
    for (int i = 0; i < 15; i++) step(1'b0, E_STMEM, "st_wait");
    step(1'b1, E_STMEM, "st_last");
    step(1'b0, E_FADDR, "st_back");

    // Store that never completes: 16 wait cycles then ERR, sticky
    fetch();
    step(1'b0, E_MAR,    "sto_addr");
    step(1'b0, E_STDATA, "sto_data");
    for (int i = 0; i < 16; i++) step(1'b0, E_STMEM, "sto_wait");
    step(1'b0, E_ERR, "sto_err");
    for (int i = 0; i < 4; i++) step(1'b1, E_ERR, "sto_err_sticky");
    do_reset("rst_err");

    // Reset held two cycles during a pending load
    set_ir(4'b0000, 2'b01, 1'b0);
    fetch();
    step(1'b0, E_MAR,  "rld_addr");
    step(1'b0, E_MEMW, "rld_wait");
    do_reset("rst_ldmem");

    // Halt absorbs for 20 cycles regardless of mem_ready
    set_ir(4'b1111, 2'b00, 1'b1);
    fetch();
    for (int i = 0; i < 20; i++) step(1'(i % 2), E_HALT, "halt");
    do_reset("rst_halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
